// File: rtl/mul_sgn_arbiter.sv
// ---------------------------------------------------------------------------
// mul_sgn_arbiter
// Shares one combinational signed Baugh-Wooley multiplier (mul_sgn) between
// NumReq requesters.  Round-robin grant, valid/ready handshakes on both the
// request and response sides, and a single outstanding operation.  Operands
// and the product are registered, so the multiplier may be constrained as a
// MulCycles multicycle path.
//
// Optional feature macro: MUL_SGN_ARB_PRIO_EN
//   When defined, an extra input req_prio_i restricts the round-robin search
//   to requesters that are both valid and prioritised (if any exist).
// ---------------------------------------------------------------------------

// Combinational signed multiplier using the modified Baugh-Wooley scheme:
// sign-related partial-product bits are inverted and a constant correction
// row is added, so every row can be summed as an unsigned number.
module mul_sgn #(
   parameter int         WidthX = 8,
   parameter int         WidthY = 8,
   parameter logic [1:0] Speed  = 2'b10
) (
   input  logic [WidthX-1:0]        x_i,
   input  logic [WidthY-1:0]        y_i,
   output logic [WidthX+WidthY-1:0] p_o
);

   localparam int PW = WidthX + WidthY;

   // Correction constant: 2^(PW-1) + 2^(WidthX-1) + 2^(WidthY-1), modulo 2^PW.
   // Added, not OR-ed, because the two lower terms coincide when WidthX == WidthY.
   localparam logic [PW-1:0] BwConst = (PW'(1) << (PW - 1))
                                     + (PW'(1) << (WidthX - 1))
                                     + (PW'(1) << (WidthY - 1));

   // Partial-product row for one Y bit, with the Baugh-Wooley inversions applied.
   function automatic logic [WidthX-1:0] pp_bits(input logic [WidthX-1:0] x,
                                                  input logic              yb,
                                                  input logic              last);
      logic [WidthX-1:0] b;
      b = x & {WidthX{yb}};
      if (last) begin
         b[WidthX-2:0] = ~b[WidthX-2:0];
      end else begin
         b[WidthX-1] = ~b[WidthX-1];
      end
      return b;
   endfunction

   logic [PW-1:0] rows_s [WidthY];
   logic [PW-1:0] acc_a_s;
   logic [PW-1:0] acc_b_s;

   // Build the shifted partial-product rows.
   always_comb begin
      for (int j = 0; j < WidthY; j++) begin
         rows_s[j] = {{WidthY{1'b0}}, pp_bits(x_i, y_i[j], (j == WidthY - 1))} << j;
      end
   end

   // Reduce the rows: two interleaved chains for speed, one chain otherwise.
   always_comb begin
      acc_a_s = BwConst;
      acc_b_s = '0;
      if (Speed[1]) begin
         for (int j = 0; j < WidthY; j++) begin
            if ((j % 2) == 1) begin
               acc_b_s = acc_b_s + rows_s[j];
            end else begin
               acc_a_s = acc_a_s + rows_s[j];
            end
         end
      end else begin
         for (int j = 0; j < WidthY; j++) begin
            acc_a_s = acc_a_s + rows_s[j];
         end
      end
      p_o = acc_a_s + acc_b_s;
   end

endmodule

module mul_sgn_arbiter #(
   parameter int         NumReq    = 4,
   parameter int         WidthX    = 8,
   parameter int         WidthY    = 8,
   parameter int         MulCycles = 1,
   parameter logic [1:0] Speed     = 2'b10
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NumReq-1:0]          req_valid_i,
   output logic [NumReq-1:0]          req_ready_o,
   input  logic [NumReq*WidthX-1:0]   req_x_i,
   input  logic [NumReq*WidthY-1:0]   req_y_i,
   output logic [NumReq-1:0]          rsp_valid_o,
   input  logic [NumReq-1:0]          rsp_ready_i,
   output logic [WidthX+WidthY-1:0]   rsp_p_o,
   output logic                       busy_o
`ifdef MUL_SGN_ARB_PRIO_EN
   ,
   input  logic [NumReq-1:0]          req_prio_i
`endif
);

   localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int SumW = IdxW + 1;
   localparam int CntW = (MulCycles > 1) ? $clog2(MulCycles) : 1;
   localparam int PW   = WidthX + WidthY;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      RESP = 2'b10
   } state_e;

   state_e              state_q,     state_d;
   logic [IdxW-1:0]     rr_ptr_q,    rr_ptr_d;
   logic [IdxW-1:0]     idx_q,       idx_d;
   logic [CntW-1:0]     cnt_q,       cnt_d;
   logic [WidthX-1:0]   x_q,         x_d;
   logic [WidthY-1:0]   y_q,         y_d;
   logic [PW-1:0]       rsp_p_q,     rsp_p_d;
   logic [NumReq-1:0]   rsp_valid_q, rsp_valid_d;
   logic                busy_q,      busy_d;

   logic [NumReq-1:0]   eligible_s;
   logic                grant_found_s;
   logic [IdxW-1:0]     grant_idx_s;
   logic [SumW-1:0]     cand_sum_s;
   logic [IdxW-1:0]     cand_s;
   logic [PW-1:0]       mul_p_s;

   // Shared multiplier, fed only from the operand registers.
   mul_sgn #(
      .WidthX (WidthX),
      .WidthY (WidthY),
      .Speed  (Speed)
   ) u_mul (
      .x_i (x_q),
      .y_i (y_q),
      .p_o (mul_p_s)
   );

`ifdef MUL_SGN_ARB_PRIO_EN
   // Restrict the search to prioritised valid requesters when any exist.
   always_comb begin
      eligible_s = req_valid_i;
      if (|(req_valid_i & req_prio_i)) begin
         eligible_s = req_valid_i & req_prio_i;
      end else begin
         eligible_s = req_valid_i;
      end
   end
`else
   // Every valid requester takes part in the round-robin search.
   always_comb begin
      eligible_s = req_valid_i;
   end
`endif

   // Round-robin search: first eligible index at or above rr_ptr, wrapping.
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      cand_sum_s    = '0;
      cand_s        = '0;
      for (int k = 0; k < NumReq; k++) begin
         cand_sum_s = {1'b0, rr_ptr_q} + SumW'(k);
         if (cand_sum_s >= SumW'(NumReq)) begin
            cand_sum_s = cand_sum_s - SumW'(NumReq);
         end else begin
            cand_sum_s = cand_sum_s;
         end
         cand_s = cand_sum_s[IdxW-1:0];
         if (!grant_found_s && eligible_s[cand_s]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand_s;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // Request accept is combinational and only offered in IDLE outside reset.
   always_comb begin
      if (rst_ni && (state_q == IDLE) && grant_found_s) begin
         req_ready_o = NumReq'(1) << grant_idx_s;
      end else begin
         req_ready_o = '0;
      end
   end

   // Next-state logic for the IDLE -> CALC -> RESP sequence.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      x_d      = x_q;
      y_d      = y_q;
      rsp_p_d  = rsp_p_q;
      case (state_q)
         IDLE: begin
            if (grant_found_s) begin
               x_d     = req_x_i[grant_idx_s*WidthX +: WidthX];
               y_d     = req_y_i[grant_idx_s*WidthY +: WidthY];
               idx_d   = grant_idx_s;
               cnt_d   = CntW'(MulCycles - 1);
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CntW'(1);
            end else begin
               rsp_p_d = mul_p_s;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready_i[idx_q]) begin
               state_d = IDLE;
               if (idx_q == IdxW'(NumReq - 1)) begin
                  rr_ptr_d = '0;
               end else begin
                  rr_ptr_d = idx_q + IdxW'(1);
               end
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered response valid and busy are decoded from the next state.
   always_comb begin
      if (state_d == RESP) begin
         rsp_valid_d = NumReq'(1) << idx_d;
      end else begin
         rsp_valid_d = '0;
      end
      busy_d = (state_d != IDLE);
   end

   // State, operand and output registers with asynchronous clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         rsp_p_q     <= '0;
         rsp_valid_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         rsp_p_q     <= rsp_p_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_p_o     = rsp_p_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_mul_sgn_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for mul_sgn_arbiter (default build, no priority port).
// A transaction-level reference model (pointer, outstanding op, age in
// cycles, product by integer arithmetic) predicts every output each cycle.
// A second instance (NumReq=1, MulCycles=3) covers the multicycle timing.
// ---------------------------------------------------------------------------
module tb_mul_sgn_arbiter;

   localparam int NR = 4;
   localparam int MC = 1;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
   logic [31:0] req_x, req_y;
   logic [15:0] rsp_p;
   logic        busy;

   logic [0:0]  v1, r1, rv1, rr1;
   logic [7:0]  x1, y1;
   logic [15:0] p1;
   logic        b1;

   always #5 clk = ~clk;

   mul_sgn_arbiter #(.NumReq(4), .WidthX(8), .WidthY(8), .MulCycles(MC), .Speed(2'b10)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_x_i(req_x), .req_y_i(req_y), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_p_o(rsp_p), .busy_o(busy));

   mul_sgn_arbiter #(.NumReq(1), .WidthX(8), .WidthY(8), .MulCycles(3), .Speed(2'b00)) dut3 (
      .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(v1), .req_ready_o(r1),
      .req_x_i(x1), .req_y_i(y1), .rsp_valid_o(rv1), .rsp_ready_i(rr1),
      .rsp_p_o(p1), .busy_o(b1));

   int checks = 0;
   int errors = 0;

   // reference model state
   bit          m_busy;
   int          m_idx, m_age, m_ptr;
   logic [15:0] m_prod, m_last_p;
   logic [7:0]  vx [4];
   logic [7:0]  vy [4];
   int          last_grant;
   int          obs_log [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      int p;
      p = $signed(a) * $signed(b);
      return p[15:0];
   endfunction

   task automatic model_reset();
      m_busy = 1'b0; m_idx = 0; m_age = 0; m_ptr = 0; m_prod = '0; m_last_p = '0;
   endtask

   // One clock cycle: drive operands, predict, compare, advance to next cycle.
   task automatic step(input string tag);
      logic [3:0]  er, ev;
      logic [15:0] ep;
      logic        eb;
      int          g;
      for (int i = 0; i < 4; i++) begin
         req_x[i*8 +: 8] = vx[i];
         req_y[i*8 +: 8] = vy[i];
      end
      #1;
      er = '0; ev = '0; eb = 1'b0; ep = m_last_p; last_grant = -1;
      if (!m_busy) begin
         g = -1;
         for (int k = 0; k < NR; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
         end
         if (g >= 0) begin
            er[g] = 1'b1; last_grant = g;
            m_busy = 1'b1; m_idx = g; m_age = 0;
            m_prod = ref_mul(vx[g], vy[g]);
         end
      end else begin
         m_age++;
         eb = 1'b1;
         if (m_age >= MC + 1) begin
            m_last_p = m_prod; ep = m_prod; ev[m_idx] = 1'b1;
            if (rsp_ready[m_idx]) begin
               m_busy = 1'b0;
               m_ptr = (m_idx + 1) % NR;
            end
         end
      end
      for (int i = 0; i < 4; i++) if (req_ready[i]) obs_log.push_back(i);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'(er));
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(ev));
      chk({tag, "_rsp_p"},     32'(rsp_p),     32'(ep));
      chk({tag, "_busy"},      32'(busy),      32'(eb));
      @(posedge clk); #1;
   endtask

   // Asynchronous reset pulse between clock edges; outputs must clear at once.
   task automatic do_reset(input string tag);
      rst_ni = 1'b0;
      #2;
      chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
      chk({tag, "_rsp_p"},     32'(rsp_p),     32'h0);
      chk({tag, "_busy"},      32'(busy),      32'h0);
      model_reset();
      req_valid = '0;
      #1;
      rst_ni = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic do_op(input string tag, input int r, input logic [7:0] x,
                        input logic [7:0] y, input logic [15:0] exp_p);
      vx[r] = x; vy[r] = y;
      req_valid = 4'(1 << r);
      step({tag, "_hs"});
      req_valid = '0;
      for (int n = 0; n < 20 && m_busy; n++) step(tag);
      chk({tag, "_const"}, 32'(rsp_p), 32'(exp_p));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int n;
      rst_ni = 1'b0; req_valid = 4'b1111; rsp_ready = 4'b1111; req_x = '0; req_y = '0;
      v1 = 1'b0; rr1 = 1'b1; x1 = '0; y1 = '0;
      for (int i = 0; i < 4; i++) begin vx[i] = '0; vy[i] = '0; end
      model_reset();
      @(posedge clk); #1;
      do_reset("reset");

      // single op with cycle-exact response, then signed corner values
      vx[0] = 8'hFD; vy[0] = 8'h05; req_valid = 4'b0001;
      step("single_c0");
      chk("single_c0_hs_done", 32'(dut.busy_o), 32'h1);
      req_valid = '0;
      step("single_c1");
      chk("single_c2_valid", 32'(rsp_valid), 32'h1);
      chk("single_c2_p", 32'(rsp_p), 32'hFFF1);
      step("single_c2");
      do_op("corner_8080", 1, 8'h80, 8'h80, 16'h4000);
      do_op("corner_807f", 2, 8'h80, 8'h7F, 16'hC080);
      do_op("corner_7f7f", 3, 8'h7F, 8'h7F, 16'h3F01);
      do_op("corner_zero", 0, 8'h00, 8'h9C, 16'h0000);

      // all requesters valid from reset: grants 0,1,2,3,0
      do_reset("rst_rr");
      for (int i = 0; i < 4; i++) begin vx[i] = 8'($urandom); vy[i] = 8'($urandom); end
      req_valid = 4'b1111; rsp_ready = 4'b1111;
      obs_log.delete();
      n = 0;
      while (obs_log.size() < 5 && n < 40) begin step("rr"); n++; end
      chk("rr_count", 32'(obs_log.size()), 32'd5);
      for (int i = 0; i < 5 && i < obs_log.size(); i++) chk("rr_order", 32'(obs_log[i]), 32'(i % 4));

      // backpressure on requester 0 while requester 2 waits
      do_reset("rst_bp");
      vx[0] = 8'h12; vy[0] = 8'hF3; vx[2] = 8'hC5; vy[2] = 8'h3A;
      req_valid = 4'b0001; rsp_ready = 4'b1110;
      step("bp_hs");
      req_valid = 4'b0100;
      step("bp_calc");
      for (int i = 0; i < 5; i++) step("bp_hold");
      rsp_ready = 4'b1111;
      step("bp_release");
      obs_log.delete();
      step("bp_next");
      chk("bp_next_grant", 32'(obs_log.size() == 1 ? obs_log[0] : -1), 32'd2);
      req_valid = '0;
      for (int i = 0; i < 3; i++) step("bp_drain");

      // asynchronous reset in the middle of CALC: no response afterwards
      vx[1] = 8'h33; vy[1] = 8'h44; req_valid = 4'b0010;
      step("mid_hs");
      req_valid = '0;
      do_reset("mid_rst");
      for (int i = 0; i < 4; i++) step("mid_after");

      // randomized traffic against the reference model
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (!req_valid[i] && $urandom_range(2) == 0) begin
               vx[i] = 8'($urandom); vy[i] = 8'($urandom); req_valid[i] = 1'b1;
            end else if (req_valid[i] && $urandom_range(15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = 4'($urandom);
         step("rand");
         if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      end
      req_valid = '0; rsp_ready = 4'b1111;
      for (int i = 0; i < 6; i++) step("rand_drain");

      // MulCycles=3 single-requester instance
      v1 = 1'b1; x1 = 8'h80; y1 = 8'h7F; rr1 = 1'b1;
      #1;
      chk("mc3_ready", 32'(r1), 32'h1);
      chk("mc3_busy0", 32'(b1), 32'h0);
      @(posedge clk); #1;
      v1 = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         #1;
         chk("mc3_busy", 32'(b1), 32'h1);
         chk("mc3_ready_low", 32'(r1), 32'h0);
         chk("mc3_valid", 32'(rv1), (c == 4) ? 32'h1 : 32'h0);
         if (c == 4) chk("mc3_p", 32'(p1), 32'hC080);
         @(posedge clk); #1;
      end
      #1;
      chk("mc3_done_busy", 32'(b1), 32'h0);
      chk("mc3_done_valid", 32'(rv1), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
